// File: rtl/rf_mp_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg: shared constants and types for the rf_mp register file.
//   rf_state_e  : clear-sequencer states (RF_ST_INIT, RF_ST_READY)
//   RF_DATA_W   : default register width
//   RF_DEPTH    : default number of registers
//   RF_ZERO     : index of the hardwired-zero register
//   rf_addr_w() : address width for a given depth (at least 1 bit)
// ----------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic {
        RF_ST_INIT  = 1'b0,
        RF_ST_READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ZERO   = 0;

    function automatic int rf_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_mp_if.sv
// ----------------------------------------------------------------------------
// rf_mp_if: register-file access bundle between the datapath and rf_mp.
//   wr_en/wr_addr/wr_data : write port (driven from WB)
//   rd_addr               : flattened read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data               : flattened read data,      port k at [k*DATA_W +: DATA_W]
//   init_done             : clear sequence complete
//   wr_err                : one-cycle pulse for a dropped write
// Modports: master (datapath side), slave (register file side).
// ----------------------------------------------------------------------------
interface rf_mp_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = rf_addr_w(RF_DEPTH),
    parameter int NUM_RD = 2
);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     init_done;
    logic                     wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, init_done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, init_done, wr_err
    );

endinterface

// File: rtl/rf_mp_clear_seq.sv
// ----------------------------------------------------------------------------
// rf_clear_seq: post-reset clear sequencer for rf_mp.
// Walks clr_addr from 0 to DEPTH-1, one entry per clock, asserting clr_we,
// then parks in READY with init_done high until the next reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_we     : clear write strobe (high throughout INIT)
//   clr_addr   : entry being cleared this cycle
//   init_done  : high once every entry has been cleared
//
//   state       | meaning
//   ------------+----------------------------------------------
//   RF_ST_INIT  | writing RESET_VAL to mem[clr_addr] each cycle
//   RF_ST_READY | clear finished, functional access enabled
// ----------------------------------------------------------------------------
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = rf_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RF_ST_INIT;
            clr_addr  <= '0;
            clr_we    <= 1'b1;
            init_done <= 1'b0;
        end else begin
            case (state)
                RF_ST_INIT: begin
                    if (clr_addr == LAST_IDX) begin
                        state     <= RF_ST_READY;
                        clr_we    <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                RF_ST_READY: begin
                    clr_we    <= 1'b0;
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= RF_ST_INIT;
                    clr_addr  <= '0;
                    clr_we    <= 1'b1;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rf_mp.sv
// ----------------------------------------------------------------------------
// rf_mp: parametrised multi-read-port register file (ID stage).
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : rf_mp_if.slave - write port, NUM_RD combinational read ports,
//                init_done and wr_err status
// After reset the clear sequencer writes RESET_VAL to every entry (DEPTH
// cycles); reads return 0 and writes are dropped with wr_err until done.
// Optional macro RF_MP_BYPASS_EN: same-cycle write data is forwarded to any
// read port addressing the entry being written.
// ----------------------------------------------------------------------------
module rf_mp
    import rf_pkg::*;
#(
    parameter int              DATA_W    = RF_DATA_W,
    parameter int              DEPTH     = RF_DEPTH,
    parameter int              ADDR_W    = rf_addr_w(DEPTH),
    parameter int              NUM_RD    = 2,
    parameter bit              ZERO_R0   = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    rf_mp_if.slave bus
);

    logic                     clr_we;
    logic [ADDR_W-1:0]        clr_addr;
    logic                     init_done;
    logic                     wr_err_q;
    logic                     wr_ok;
    logic                     fn_we;
    logic [NUM_RD*DATA_W-1:0] rd_flat;
    logic [DATA_W-1:0]        mem [DEPTH];

    // Widened to 32 bits so the compare stays meaningful when DEPTH is a
    // power of two and every address is in range.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
        return ZERO_R0 && (32'(a) == RF_ZERO);
    endfunction

    rf_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign wr_ok = addr_ok(bus.wr_addr) && !is_r0(bus.wr_addr);
    assign fn_we = bus.wr_en && init_done && wr_ok;

    // Storage has no reset; the clear sequencer owns the write port in INIT.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= RESET_VAL;
        end else if (fn_we) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // r0 writes are silently absorbed; only INIT and out-of-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.wr_en && (!init_done || !addr_ok(bus.wr_addr));
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        a       = '0;
        rd_flat = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (init_done && addr_ok(a) && !is_r0(a)) begin
                rd_flat[k*DATA_W +: DATA_W] = mem[a];
            end
`ifdef RF_MP_BYPASS_EN
            if (fn_we && (bus.wr_addr == a)) begin
                rd_flat[k*DATA_W +: DATA_W] = bus.wr_data;
            end
`endif
        end
    end

    assign bus.rd_data   = rd_flat;
    assign bus.init_done = init_done;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_rf_mp.sv
module tb_rf_mp;
    import rf_pkg::*;

    localparam logic [31:0] RV_B = 32'h5A5A_0F0F;

    logic clk = 1'b0;
    logic rst_na = 1'b0;
    logic rst_nb = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   err_cnt;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    rf_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    rf_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus_b ();

    rf_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (bus_a)
    );

    rf_mp #(.DATA_W(32), .DEPTH(24), .NUM_RD(4), .RESET_VAL(RV_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    function automatic logic [31:0] rd_a(input int k);
        return bus_a.rd_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_b(input int k);
        return bus_b.rd_data[k*32 +: 32];
    endfunction

    initial begin
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rd_addr = '0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.rd_addr = '0;
        #22;
        expect_val(32'd0); check("rst_init_done_a", 32'(bus_a.init_done));
        expect_val(32'd0); check("rst_wr_err_a", 32'(bus_a.wr_err));

        // Release both resets between edges; A writes r5 during the first 3 INIT cycles.
        @(negedge clk);
        rst_na = 1'b1;
        rst_nb = 1'b1;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hFFFF_FFFF;
        bus_b.rd_addr[0 +: 5] = 5'd3;
        err_cnt = 0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (bus_a.wr_err) err_cnt++;
            if (c == 3) bus_a.wr_en = 1'b0;
            if (c == 10) begin expect_val(32'd0); check("init_read_zero_b", rd_b(0)); end
            if (c == 23) begin expect_val(32'd0); check("init_done_b_c23", 32'(bus_b.init_done)); end
            if (c == 24) begin expect_val(32'd1); check("init_done_b_c24", 32'(bus_b.init_done)); end
            if (c == 31) begin expect_val(32'd0); check("init_done_a_c31", 32'(bus_a.init_done)); end
            if (c == 32) begin expect_val(32'd1); check("init_done_a_c32", 32'(bus_a.init_done)); end
        end
        expect_val(32'd3); check("init_wr_err_pulses", 32'(err_cnt));
        bus_a.rd_addr[0 +: 5] = 5'd5;
        #1;
        expect_val(32'd0); check("r5_after_clear_a", rd_a(0));

        // r7 write, read on both ports next cycle.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'hDEAD_BEEF;
        tick();
        bus_a.wr_en = 1'b0;
        bus_a.rd_addr = {5'd7, 5'd7};
        #1;
        expect_val(32'hDEAD_BEEF); check("r7_port0", rd_a(0));
        expect_val(32'hDEAD_BEEF); check("r7_port1", rd_a(1));

        // r0 write is absorbed without error.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h0000_1234;
        tick();
        bus_a.wr_en = 1'b0;
        expect_val(32'd0); check("r0_wr_err", 32'(bus_a.wr_err));
        bus_a.rd_addr[0 +: 5] = 5'd0;
        #1;
        expect_val(32'd0); check("r0_reads_zero", rd_a(0));

        // Out-of-range write on DEPTH=24.
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd30; bus_b.wr_data = 32'hBAD0_BAD0;
        tick();
        bus_b.wr_en = 1'b0;
        expect_val(32'd1); check("oor_wr_err_pulse", 32'(bus_b.wr_err));
        bus_b.rd_addr[0 +: 5] = 5'd30;
        bus_b.rd_addr[5 +: 5] = 5'd14;
        bus_b.rd_addr[10 +: 5] = 5'd22;
        tick();
        expect_val(32'd0); check("oor_wr_err_single", 32'(bus_b.wr_err));
        expect_val(32'd0); check("oor_read_zero", rd_b(0));
        expect_val(RV_B); check("oor_r14_unchanged", rd_b(1));
        expect_val(RV_B); check("oor_r22_unchanged", rd_b(2));

        // Same-cycle write/read of r9.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd9; bus_a.wr_data = 32'h1111_2222;
        tick();
        bus_a.wr_data = 32'hA5A5_A5A5;
        bus_a.rd_addr[5 +: 5] = 5'd9;
        #1;
`ifdef RF_MP_BYPASS_EN
        expect_val(32'hA5A5_A5A5);
`else
        expect_val(32'h1111_2222);
`endif
        check("r9_same_cycle", rd_a(1));
        tick();
        bus_a.wr_en = 1'b0;
        #1;
        expect_val(32'hA5A5_A5A5); check("r9_next_cycle", rd_a(1));

        // Four read ports, distinct addresses.
        for (int i = 1; i <= 4; i++) begin
            bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'(i); bus_b.wr_data = 32'(i * 32'h11);
            tick();
        end
        bus_b.wr_en = 1'b0;
        bus_b.rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int k = 0; k < 4; k++) begin
            expect_val(32'((k + 1) * 32'h11)); check($sformatf("mp_fwd_port%0d", k), rd_b(k));
        end
        bus_b.rd_addr = {5'd1, 5'd2, 5'd3, 5'd4};
        #1;
        for (int k = 0; k < 4; k++) begin
            expect_val(32'((4 - k) * 32'h11)); check($sformatf("mp_rev_port%0d", k), rd_b(k));
        end

        // Reset mid-clear at clr_idx=10, then full restart.
        @(negedge clk);
        rst_nb = 1'b0;
        #2;
        @(negedge clk);
        rst_nb = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        #2;
        rst_nb = 1'b0;
        #2;
        @(negedge clk);
        rst_nb = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 23) begin expect_val(32'd0); check("restart_done_c23", 32'(bus_b.init_done)); end
            if (c == 24) begin expect_val(32'd1); check("restart_done_c24", 32'(bus_b.init_done)); end
        end

        // Write r3, then reset in READY.
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd3; bus_b.wr_data = 32'h0000_0055;
        tick();
        bus_b.wr_en = 1'b0;
        bus_b.rd_addr[0 +: 5] = 5'd3;
        #1;
        expect_val(32'h0000_0055); check("r3_written", rd_b(0));
        #1;
        rst_nb = 1'b0;
        #1;
        expect_val(32'd0); check("ready_rst_init_done_drop", 32'(bus_b.init_done));
        expect_val(32'd0); check("ready_rst_read_zero", rd_b(0));
        @(negedge clk);
        rst_nb = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 23) begin expect_val(32'd0); check("reclear_done_c23", 32'(bus_b.init_done)); end
            if (c == 24) begin expect_val(32'd1); check("reclear_done_c24", 32'(bus_b.init_done)); end
        end
        expect_val(RV_B); check("r3_reset_val", rd_b(0));

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
